// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage: owns the PC, captures Instr_code into
//               the IF/ID register, handles stall, redirect/flush and the
//               end-of-memory halt. Optional counter enabled by FETCH_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int          MEM_BYTES = 36,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] Instr_code,
    output logic [31:0] PC,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        fetch_done,
    output logic        fetch_err,
    output logic [31:0] instr_count
);

    localparam logic [31:0] c_LAST_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc;
    logic        r_ifid_valid;
    logic        r_fetch_done;
    logic        r_fetch_err;

    logic [31:0] w_pc_inc;
    logic        w_redir_bad;
    logic        w_last_word;

    assign w_pc_inc    = r_pc + 32'd4;
    assign w_redir_bad = (redirect_pc[1:0] != 2'b00) || (redirect_pc > c_LAST_ADDR);
    // PC never advances past the last word, so this add cannot wrap.
    assign w_last_word = (w_pc_inc > c_LAST_ADDR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_BOOT;
            r_pc         <= RESET_PC;
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= 32'd0;
            r_ifid_pc    <= 32'd0;
            r_fetch_done <= 1'b0;
            r_fetch_err  <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_ifid_valid <= 1'b0;
                    r_state      <= S_RUN;
                end

                S_RUN: begin
                    if (redirect_valid) begin
                        r_ifid_valid <= 1'b0;
                        if (w_redir_bad) begin
                            r_fetch_err <= 1'b1;
                            r_state     <= S_HALT;
                        end else begin
                            r_pc        <= redirect_pc;
                            r_fetch_err <= 1'b0;
                        end
                    end else if (!stall_in) begin
                        r_ifid_instr <= Instr_code;
                        r_ifid_pc    <= r_pc;
                        r_ifid_valid <= 1'b1;
                        if (w_last_word) begin
                            r_fetch_done <= 1'b1;
                            r_state      <= S_HALT;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end

                S_HALT: begin
                    if (redirect_valid) begin
                        r_ifid_valid <= 1'b0;
                        if (w_redir_bad) begin
                            r_fetch_err <= 1'b1;
                        end else begin
                            r_pc         <= redirect_pc;
                            r_fetch_done <= 1'b0;
                            r_fetch_err  <= 1'b0;
                            r_state      <= S_RUN;
                        end
                    end else if (!stall_in) begin
                        // Last captured word is consumed; nothing new follows.
                        r_ifid_valid <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    assign PC         = r_pc;
    assign ifid_valid = r_ifid_valid;
    assign ifid_instr = r_ifid_instr;
    assign ifid_pc    = r_ifid_pc;
    assign fetch_done = r_fetch_done;
    assign fetch_err  = r_fetch_err;

`ifdef FETCH_CNT_EN
    logic [31:0] r_instr_count;
    logic        w_capture;

    assign w_capture = (r_state == S_RUN) && !redirect_valid && !stall_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr_count <= 32'd0;
        end else if (w_capture && (r_instr_count != 32'hFFFF_FFFF)) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign instr_count = r_instr_count;
`else
    assign instr_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Table-driven, scoreboard-checked bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] Instr_code;
    logic [31:0] PC;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        fetch_done;
    logic        fetch_err;
    logic [31:0] instr_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:8];

    fetch_unit #(.MEM_BYTES(36), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .Instr_code     (Instr_code),
        .PC             (PC),
        .ifid_valid     (ifid_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .fetch_done     (fetch_done),
        .fetch_err      (fetch_err),
        .instr_count    (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign Instr_code = (PC < 32'd36) ? mem[PC[5:2]] : 32'h0;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic [31:0] e_pc;
        logic        e_done;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   vec_id = 0;

    function automatic vec_t mk(input logic s, input logic rv, input logic [31:0] rpc,
                                input logic ev, input logic [31:0] ei, input logic [31:0] eipc,
                                input logic [31:0] epc, input logic ed, input logic ee);
        vec_t r;
        r.stall = s;  r.rv = rv;  r.rpc = rpc;
        r.e_valid = ev; r.e_instr = ei; r.e_ipc = eipc;
        r.e_pc = epc; r.e_done = ed; r.e_err = ee;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic run_vec(input vec_t v);
        vec_t e;
        stall_in       = v.stall;
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk($sformatf("v%0d.valid", vec_id), {31'd0, ifid_valid}, {31'd0, e.e_valid});
        chk($sformatf("v%0d.pc",    vec_id), PC, e.e_pc);
        chk($sformatf("v%0d.done",  vec_id), {31'd0, fetch_done}, {31'd0, e.e_done});
        chk($sformatf("v%0d.err",   vec_id), {31'd0, fetch_err}, {31'd0, e.e_err});
        if (e.e_valid) begin
            chk($sformatf("v%0d.instr", vec_id), ifid_instr, e.e_instr);
            chk($sformatf("v%0d.ipc",   vec_id), ifid_pc, e.e_ipc);
        end
        vec_id++;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".pc"},    PC, 32'h0);
        chk({tag, ".valid"}, {31'd0, ifid_valid}, 32'd0);
        chk({tag, ".instr"}, ifid_instr, 32'h0);
        chk({tag, ".ipc"},   ifid_pc, 32'h0);
        chk({tag, ".done"},  {31'd0, fetch_done}, 32'd0);
        chk({tag, ".err"},   {31'd0, fetch_err}, 32'd0);
        chk({tag, ".cnt"},   instr_count, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[0] = 32'h00011020; mem[1] = 32'h00853022; mem[2] = 32'h01095024;
        mem[3] = 32'h01285025; mem[4] = 32'h01660180; mem[5] = 32'h01A90282;
        mem[6] = 32'hFC20000D; mem[7] = 32'h00000013; mem[8] = 32'h0000ABCD;

        //            stall rv  rpc    valid instr          ipc    PC     done err
        tbl.push_back(mk(0, 0, 32'h00, 0, 32'h0,        32'h00, 32'h00, 0, 0)); // BOOT
        tbl.push_back(mk(0, 0, 32'h00, 1, 32'h00011020, 32'h00, 32'h04, 0, 0));
        tbl.push_back(mk(0, 0, 32'h00, 1, 32'h00853022, 32'h04, 32'h08, 0, 0));
        tbl.push_back(mk(0, 0, 32'h00, 1, 32'h01095024, 32'h08, 32'h0C, 0, 0));
        tbl.push_back(mk(1, 0, 32'h00, 1, 32'h01095024, 32'h08, 32'h0C, 0, 0)); // stall x3
        tbl.push_back(mk(1, 0, 32'h00, 1, 32'h01095024, 32'h08, 32'h0C, 0, 0));
        tbl.push_back(mk(1, 0, 32'h00, 1, 32'h01095024, 32'h08, 32'h0C, 0, 0));
        tbl.push_back(mk(0, 0, 32'h00, 1, 32'h01285025, 32'h0C, 32'h10, 0, 0));
        tbl.push_back(mk(1, 1, 32'h18, 0, 32'h0,        32'h00, 32'h18, 0, 0)); // redirect beats stall
        tbl.push_back(mk(0, 0, 32'h00, 1, 32'hFC20000D, 32'h18, 32'h1C, 0, 0));
        tbl.push_back(mk(0, 0, 32'h00, 1, 32'h00000013, 32'h1C, 32'h20, 0, 0));
        tbl.push_back(mk(0, 0, 32'h00, 1, 32'h0000ABCD, 32'h20, 32'h20, 1, 0)); // last word
        tbl.push_back(mk(1, 0, 32'h00, 1, 32'h0000ABCD, 32'h20, 32'h20, 1, 0)); // stall in HALT holds
        tbl.push_back(mk(0, 0, 32'h00, 0, 32'h0,        32'h00, 32'h20, 1, 0));
        tbl.push_back(mk(0, 1, 32'h00, 0, 32'h0,        32'h00, 32'h00, 0, 0)); // HALT -> RUN
        tbl.push_back(mk(0, 1, 32'h22, 0, 32'h0,        32'h00, 32'h00, 0, 1)); // misaligned
        tbl.push_back(mk(0, 1, 32'h24, 0, 32'h0,        32'h00, 32'h00, 0, 1)); // out of range
        tbl.push_back(mk(0, 0, 32'h00, 0, 32'h0,        32'h00, 32'h00, 0, 1)); // no fetch in HALT
        tbl.push_back(mk(0, 1, 32'h04, 0, 32'h0,        32'h00, 32'h04, 0, 0));
        tbl.push_back(mk(0, 0, 32'h00, 1, 32'h00853022, 32'h04, 32'h08, 0, 0));
        tbl.push_back(mk(0, 1, 32'h20, 0, 32'h0,        32'h00, 32'h20, 0, 0)); // last legal addr
        tbl.push_back(mk(0, 0, 32'h00, 1, 32'h0000ABCD, 32'h20, 32'h20, 1, 0));
        tbl.push_back(mk(0, 1, 32'h10, 0, 32'h0,        32'h00, 32'h10, 0, 0));

        reset          = 1'b0;
        stall_in       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("por");

        @(negedge clk);
        reset = 1'b1;
        foreach (tbl[i]) run_vec(tbl[i]);

        // Asynchronous reset in mid-cycle, PC currently 0x10.
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_state("midrst");

        @(negedge clk);
        reset = 1'b1;
        run_vec(mk(0, 1, 32'h18, 0, 32'h0, 32'h0, 32'h00, 0, 0)); // redirect ignored in BOOT
        for (int k = 0; k < 9; k++) begin
            run_vec(mk(0, 0, 32'h0, 1, mem[k], 32'(k * 4),
                       (k == 8) ? 32'h20 : 32'((k + 1) * 4), (k == 8), 0));
        end
`ifdef FETCH_CNT_EN
        chk("count.pass", instr_count, 32'd9);
`else
        chk("count.pass", instr_count, 32'd0);
`endif
        run_vec(mk(0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h20, 1, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
